// File: rtl/rib_wr_buffer_pkg.sv
// Shared widths, constants and drain-FSM state encodings for the RIB posted-write buffer.
package rib_wr_buffer_pkg;

    localparam int RIBWB_ADDR_W = 32;
    localparam int RIBWB_DATA_W = 32;

    localparam logic [RIBWB_DATA_W-1:0] ZERO_WORD = '0;

    typedef enum logic {
        RIBWB_IDLE = 1'b0,
        RIBWB_SEND = 1'b1
    } ribwbState_e;

endpackage

// File: rtl/rib_wr_buffer_if.sv
// Bus bundle between the execute unit (RIB side), the write buffer and the slow data memory.
interface rib_wr_buffer_if
    import rib_wr_buffer_pkg::*;
#(
    parameter int ADDR_W = RIBWB_ADDR_W,
    parameter int DATA_W = RIBWB_DATA_W
) ();

    logic              wr_rib_req_i;
    logic              wr_en_i;
    logic [ADDR_W-1:0] wr_addr_i;
    logic [DATA_W-1:0] wr_data_i;
    logic [ADDR_W-1:0] rd_addr_i;
    logic [DATA_W-1:0] rd_data_o;
    logic              hold_flag_o;
    logic              overflow_o;
    logic              m_req_o;
    logic [ADDR_W-1:0] m_addr_o;
    logic [DATA_W-1:0] m_wdata_o;
    logic              m_ack_i;
    logic [ADDR_W-1:0] m_rd_addr_o;
    logic [DATA_W-1:0] m_rdata_i;

    // The buffer is the responder toward the execute unit and the requester toward memory.
    modport slave (
        input  wr_rib_req_i, wr_en_i, wr_addr_i, wr_data_i, rd_addr_i,
        input  m_ack_i, m_rdata_i,
        output rd_data_o, hold_flag_o, overflow_o,
        output m_req_o, m_addr_o, m_wdata_o, m_rd_addr_o
    );

    modport master (
        output wr_rib_req_i, wr_en_i, wr_addr_i, wr_data_i, rd_addr_i,
        output m_ack_i, m_rdata_i,
        input  rd_data_o, hold_flag_o, overflow_o,
        input  m_req_o, m_addr_o, m_wdata_o, m_rd_addr_o
    );

endinterface

// File: rtl/rib_wb_fifo.sv
// Posted-write storage: circular buffer of {word address, data} with per-entry valid bits
// exposed so the parent can forward reads from any buffered write.
module rib_wb_fifo
    import rib_wr_buffer_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int AW     = RIBWB_ADDR_W - 2,
    parameter int DATA_W = RIBWB_DATA_W,
    parameter int PTR_W  = $clog2(DEPTH),
    parameter int CNT_W  = PTR_W + 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push_i,
    input  logic [AW-1:0]                  pushAddr_i,
    input  logic [DATA_W-1:0]              pushData_i,
    input  logic                           pop_i,
    output logic [AW-1:0]                  headAddr_o,
    output logic [DATA_W-1:0]              headData_o,
    output logic [AW-1:0]                  nextAddr_o,
    output logic [DATA_W-1:0]              nextData_o,
    output logic [CNT_W-1:0]               count_o,
    output logic                           full_o,
    output logic                           empty_o,
    output logic [PTR_W-1:0]               rdPtr_o,
    output logic [DEPTH-1:0]               valid_o,
    output logic [DEPTH-1:0][AW-1:0]       entAddr_o,
    output logic [DEPTH-1:0][DATA_W-1:0]   entData_o
);

    logic [DEPTH-1:0][AW-1:0]     addrMem_q;
    logic [DEPTH-1:0][DATA_W-1:0] dataMem_q;
    logic [PTR_W-1:0]             wrPtr_q;
    logic [PTR_W-1:0]             rdPtr_q;
    logic [PTR_W-1:0]             nextPtr;
    logic [CNT_W-1:0]             count_q;
    logic [CNT_W-1:0]             count_d;
    logic [DEPTH-1:0]             valid_q;
    logic [DEPTH-1:0]             valid_d;

    always_comb begin
        valid_d = valid_q;
        count_d = count_q;
        if (pop_i) begin
            valid_d[rdPtr_q] = 1'b0;
        end
        if (push_i) begin
            valid_d[wrPtr_q] = 1'b1;
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage itself is not reset; the valid bits and count decide what is live.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            if (push_i) begin
                addrMem_q[wrPtr_q] <= pushAddr_i;
                dataMem_q[wrPtr_q] <= pushData_i;
                wrPtr_q            <= wrPtr_q + 1'b1;
            end
            if (pop_i) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    assign nextPtr    = rdPtr_q + 1'b1;
    assign headAddr_o = addrMem_q[rdPtr_q];
    assign headData_o = dataMem_q[rdPtr_q];
    assign nextAddr_o = addrMem_q[nextPtr];
    assign nextData_o = dataMem_q[nextPtr];
    assign count_o    = count_q;
    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign rdPtr_o    = rdPtr_q;
    assign valid_o    = valid_q;
    assign entAddr_o  = addrMem_q;
    assign entData_o  = dataMem_q;

endmodule

// File: rtl/rib_wr_buffer.sv
// RIB write responder: posts word writes into a small FIFO, drains them to memory over
// req/ack, forwards reads that hit buffered data and stalls the PC before overflow.
module rib_wr_buffer
    import rib_wr_buffer_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = RIBWB_ADDR_W,
    parameter int DATA_W = RIBWB_DATA_W
) (
    input  logic            clk,
    input  logic            rst,
    rib_wr_buffer_if.slave  bus
);

    localparam int AW    = ADDR_W - 2;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] HOLD_LEVEL = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] ONE_LEFT   = CNT_W'(1);

    ribwbState_e                 state_q;
    logic                        mReq_q;
    logic [ADDR_W-1:0]           mAddr_q;
    logic [DATA_W-1:0]           mWdata_q;
    logic                        overflow_q;
    logic                        hit_q;
    logic                        hit_d;
    logic [DATA_W-1:0]           fwd_q;
    logic [DATA_W-1:0]           fwd_d;

    logic                        wrValid;
    logic                        push;
    logic                        pop;
    logic [AW-1:0]               wrWord;
    logic [AW-1:0]               rdWord;
    logic                        unusedAddrBits;

    logic [AW-1:0]               headAddr;
    logic [DATA_W-1:0]           headData;
    logic [AW-1:0]               nextAddr;
    logic [DATA_W-1:0]           nextData;
    logic [CNT_W-1:0]            fifoCount;
    logic                        fifoFull;
    logic                        fifoEmpty;
    logic [PTR_W-1:0]            rdPtr;
    logic [DEPTH-1:0]            entValid;
    logic [DEPTH-1:0][AW-1:0]    entAddr;
    logic [DEPTH-1:0][DATA_W-1:0] entData;

    assign wrValid        = bus.wr_rib_req_i && bus.wr_en_i;
    assign push           = wrValid && !fifoFull;
    assign pop            = (state_q == RIBWB_SEND) && bus.m_ack_i;
    assign wrWord         = bus.wr_addr_i[ADDR_W-1:2];
    assign rdWord         = bus.rd_addr_i[ADDR_W-1:2];
    assign unusedAddrBits = ^{bus.wr_addr_i[1:0], bus.rd_addr_i[1:0]};

    rib_wb_fifo #(
        .DEPTH  (DEPTH),
        .AW     (AW),
        .DATA_W (DATA_W),
        .PTR_W  (PTR_W),
        .CNT_W  (CNT_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push),
        .pushAddr_i (wrWord),
        .pushData_i (bus.wr_data_i),
        .pop_i      (pop),
        .headAddr_o (headAddr),
        .headData_o (headData),
        .nextAddr_o (nextAddr),
        .nextData_o (nextData),
        .count_o    (fifoCount),
        .full_o     (fifoFull),
        .empty_o    (fifoEmpty),
        .rdPtr_o    (rdPtr),
        .valid_o    (entValid),
        .entAddr_o  (entAddr),
        .entData_o  (entData)
    );

    // Walk oldest to youngest so a younger match overrides; a same-cycle push wins over all.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx   = '0;
        hit_d = 1'b0;
        fwd_d = fwd_q;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rdPtr + PTR_W'(k);
            if (entValid[idx] && (entAddr[idx] == rdWord)) begin
                hit_d = 1'b1;
                fwd_d = entData[idx];
            end
        end
        if (push && (wrWord == rdWord)) begin
            hit_d = 1'b1;
            fwd_d = bus.wr_data_i;
        end
    end

    // The next payload is loaded on the ack edge, so req can stay high back-to-back.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RIBWB_IDLE;
            mReq_q     <= 1'b0;
            mAddr_q    <= '0;
            mWdata_q   <= ZERO_WORD;
            overflow_q <= 1'b0;
            hit_q      <= 1'b0;
            fwd_q      <= ZERO_WORD;
        end else begin
            hit_q <= hit_d;
            fwd_q <= fwd_d;
            if (wrValid && fifoFull) begin
                overflow_q <= 1'b1;
            end
            unique case (state_q)
                RIBWB_IDLE: begin
                    if (!fifoEmpty) begin
                        state_q  <= RIBWB_SEND;
                        mReq_q   <= 1'b1;
                        mAddr_q  <= {headAddr, 2'b00};
                        mWdata_q <= headData;
                    end
                end
                RIBWB_SEND: begin
                    if (bus.m_ack_i) begin
                        if (fifoCount > ONE_LEFT) begin
                            mAddr_q  <= {nextAddr, 2'b00};
                            mWdata_q <= nextData;
                        end else begin
                            state_q <= RIBWB_IDLE;
                            mReq_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= RIBWB_IDLE;
                    mReq_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rd_data_o   = hit_q ? fwd_q : bus.m_rdata_i;
    assign bus.hold_flag_o = (fifoCount >= HOLD_LEVEL);
    assign bus.overflow_o  = overflow_q;
    assign bus.m_req_o     = mReq_q;
    assign bus.m_addr_o    = mAddr_q;
    assign bus.m_wdata_o   = mWdata_q;
    assign bus.m_rd_addr_o = bus.rd_addr_i;

endmodule

// File: tb/tb_rib_wr_buffer.sv
// Directed bench for rib_wr_buffer: each step drives inputs, takes one clock edge,
// then checks outputs 1 time unit after the edge against hand-computed values.
module tb_rib_wr_buffer;

    logic clk;
    logic rst;
    int   vectorCount;
    int   errCount;

    rib_wr_buffer_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    rib_wr_buffer #(
        .DEPTH  (4),
        .ADDR_W (32),
        .DATA_W (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic wrReq, input logic [31:0] wAddr,
                                 input logic [31:0] wData, input logic [31:0] rdAddr,
                                 input logic ack);
        bus.wr_rib_req_i = wrReq;
        bus.wr_en_i      = wrReq;
        bus.wr_addr_i    = wAddr;
        bus.wr_data_i    = wData;
        bus.rd_addr_i    = rdAddr;
        bus.m_ack_i      = ack;
        tick();
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectorCount++;
        assert (observed === expected)
        else begin
            errCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        vectorCount      = 0;
        errCount         = 0;
        rst              = 1'b1;
        bus.wr_rib_req_i = 1'b0;
        bus.wr_en_i      = 1'b0;
        bus.wr_addr_i    = '0;
        bus.wr_data_i    = '0;
        bus.rd_addr_i    = '0;
        bus.m_ack_i      = 1'b0;
        bus.m_rdata_i    = 32'hCAFE_0000;
        tick();
        tick();
        checkOutput("rst_m_req",    {31'd0, bus.m_req_o},     32'd0);
        checkOutput("rst_hold",     {31'd0, bus.hold_flag_o}, 32'd0);
        checkOutput("rst_overflow", {31'd0, bus.overflow_o},  32'd0);
        checkOutput("rst_m_addr",   bus.m_addr_o,             32'd0);
        checkOutput("rst_m_wdata",  bus.m_wdata_o,            32'd0);
        checkOutput("rst_rd_data",  bus.rd_data_o,            32'hCAFE_0000);
        rst = 1'b0;

        $display("[TB] single write drains to memory");
        applyStimulus(1'b1, 32'h1000, 32'hDEAD_BEEF, 32'h0, 1'b0);
        checkOutput("t1_req_idle",  {31'd0, bus.m_req_o},     32'd0);
        checkOutput("t1_hold_idle", {31'd0, bus.hold_flag_o}, 32'd0);
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        checkOutput("t1_req_send",  {31'd0, bus.m_req_o},     32'd1);
        checkOutput("t1_m_addr",    bus.m_addr_o,             32'h1000);
        checkOutput("t1_m_wdata",   bus.m_wdata_o,            32'hDEAD_BEEF);
        checkOutput("t1_rd_addr",   bus.m_rd_addr_o,          32'h0);
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
        checkOutput("t1_req_done",  {31'd0, bus.m_req_o},     32'd0);
        checkOutput("t1_hold_done", {31'd0, bus.hold_flag_o}, 32'd0);

        $display("[TB] fill to full and overflow");
        applyStimulus(1'b1, 32'h0, 32'hA0, 32'h0, 1'b0);
        checkOutput("t2_hold_1", {31'd0, bus.hold_flag_o}, 32'd0);
        applyStimulus(1'b1, 32'h4, 32'hA1, 32'h0, 1'b0);
        checkOutput("t2_hold_2", {31'd0, bus.hold_flag_o}, 32'd0);
        applyStimulus(1'b1, 32'h8, 32'hA2, 32'h0, 1'b0);
        checkOutput("t2_hold_3", {31'd0, bus.hold_flag_o}, 32'd1);
        applyStimulus(1'b1, 32'hC, 32'hA3, 32'h0, 1'b0);
        checkOutput("t2_ovf_4",  {31'd0, bus.overflow_o},  32'd0);
        applyStimulus(1'b1, 32'h10, 32'hA4, 32'h0, 1'b0);
        checkOutput("t2_ovf_5",  {31'd0, bus.overflow_o},  32'd1);
        checkOutput("t2_req",    {31'd0, bus.m_req_o},     32'd1);
        checkOutput("t2_head",   bus.m_addr_o,             32'h0);
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h8, 1'b0);
        checkOutput("t2_fwd_old", bus.rd_data_o, 32'hA2);
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h10, 1'b0);
        checkOutput("t2_drop_nofwd", bus.rd_data_o, 32'hCAFE_0000);

        $display("[TB] pop and write at full");
        applyStimulus(1'b1, 32'h14, 32'hA5, 32'h14, 1'b1);
        checkOutput("t5_m_addr",  bus.m_addr_o,             32'h4);
        checkOutput("t5_m_wdata", bus.m_wdata_o,            32'hA1);
        checkOutput("t5_req",     {31'd0, bus.m_req_o},     32'd1);
        checkOutput("t5_hold",    {31'd0, bus.hold_flag_o}, 32'd1);
        checkOutput("t5_ovf",     {31'd0, bus.overflow_o},  32'd1);
        checkOutput("t5_nofwd",   bus.rd_data_o,            32'hCAFE_0000);
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h4, 1'b1);
        checkOutput("t5_fwd_pop", bus.rd_data_o,            32'hA1);
        checkOutput("t5_addr_2",  bus.m_addr_o,             32'h8);
        checkOutput("t5_hold_2",  {31'd0, bus.hold_flag_o}, 32'd0);
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
        checkOutput("t5_addr_3",  bus.m_addr_o,             32'hC);
        checkOutput("t5_data_3",  bus.m_wdata_o,            32'hA3);
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
        checkOutput("t5_req_end", {31'd0, bus.m_req_o},     32'd0);
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        checkOutput("t5_req_stay", {31'd0, bus.m_req_o},    32'd0);

        $display("[TB] youngest-entry and same-cycle forwarding");
        bus.m_rdata_i = 32'h1234_5678;
        applyStimulus(1'b1, 32'h20, 32'h11, 32'h0, 1'b0);
        applyStimulus(1'b1, 32'h20, 32'h22, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h20, 1'b0);
        checkOutput("t3_youngest", bus.rd_data_o, 32'h22);
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h24, 1'b0);
        checkOutput("t3_miss",     bus.rd_data_o, 32'h1234_5678);
        applyStimulus(1'b1, 32'h40, 32'hAB, 32'h40, 1'b0);
        checkOutput("t4_same_cyc", bus.rd_data_o,             32'hAB);
        checkOutput("t4_hold",     {31'd0, bus.hold_flag_o},  32'd1);
        checkOutput("t4_req",      {31'd0, bus.m_req_o},      32'd1);
        checkOutput("t4_ovf_pre",  {31'd0, bus.overflow_o},   32'd1);

        $display("[TB] reset during handshake");
        rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        rst = 1'b0;
        checkOutput("t6_req",    {31'd0, bus.m_req_o},     32'd0);
        checkOutput("t6_hold",   {31'd0, bus.hold_flag_o}, 32'd0);
        checkOutput("t6_ovf",    {31'd0, bus.overflow_o},  32'd0);
        checkOutput("t6_m_addr", bus.m_addr_o,             32'd0);
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h40, 1'b1);
        checkOutput("t6_nofwd",  bus.rd_data_o,            32'h1234_5678);
        checkOutput("t6_req_2",  {31'd0, bus.m_req_o},     32'd0);
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        checkOutput("t6_req_3",  {31'd0, bus.m_req_o},     32'd0);
        checkOutput("t6_hold_3", {31'd0, bus.hold_flag_o}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, errCount);
        $finish;
    end

endmodule
